// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, sample type, FSM states and saturation helper for the audio front end.
package audio_pkg;
  localparam int W = 32;
  localparam int N = 100;
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(N + 1);
  typedef logic signed [W-1:0] sample_t;
  typedef enum logic [2:0] {IDLE, ABS, NORM, STREAM, FIN} state_t;
  localparam sample_t SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(W-1){1'b0}}};
  // in range exactly when the bits above the result's sign bit are all copies of it
  function automatic sample_t sat(input logic [2*W-1:0] v);
    return (&v[2*W-1:W-1] || ~|v[2*W-1:W-1]) ? sample_t'(v[W-1:0]) : (v[2*W-1] ? SAT_MIN : SAT_MAX);
  endfunction
endpackage

// File: rtl/audio_norm_shift_calc.sv
// audio_norm_shift_calc: finds the frame peak magnitude, then walks the left-shift up one bit per cycle.
module audio_norm_shift_calc
  import audio_pkg::*;
#(
  parameter int HEADROOM = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  sample_t       mx,
  input  sample_t       mn,
  output logic          done,
  output logic [SW-1:0] shift
);
  localparam logic [2*W-1:0] T = (2*W)'(1) << (W - 1 - HEADROOM);
  localparam logic [SW-1:0] KMAX = SW'(W - 2);
  logic [W:0] ax, an, peak_c, peak;
  logic [SW-1:0] k, k1;
  logic run, grow;
  // one extra bit keeps |-2^(W-1)| representable
  always_comb begin
    ax = mx[W-1] ? -{mx[W-1], mx} : {mx[W-1], mx};
    an = mn[W-1] ? -{mn[W-1], mn} : {mn[W-1], mn};
    peak_c = ax > an ? ax : an;
    k1 = k + 1'b1;
    grow = (({{(W-1){1'b0}}, peak} << k1) < T) && (k < KMAX);
    done = start ? (peak_c == '0) : (run && !grow);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      k <= '0;
      peak <= '0;
      shift <= '0;
    end else if (start) begin
      peak <= peak_c;
      k <= '0;
      run <= peak_c != '0;
      if (peak_c == '0) shift <= '0;
    end else if (run) begin
      if (grow) k <= k1;
      else begin
        shift <= k;
        run <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/audio_peak_normalizer.sv
// audio_peak_normalizer: per-frame peak normalisation; searches a gain shift, then streams the frame through with saturation.
module audio_peak_normalizer
  import audio_pkg::*;
#(
  parameter int HEADROOM = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mm_done,
  input  sample_t       in_max,
  input  sample_t       in_min,
  input  logic          s_valid,
  output logic          s_ready,
  input  sample_t       s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output sample_t       m_data,
  output logic [SW-1:0] shift,
  output logic          busy,
  output logic          done
);
  localparam logic [CW-1:0] NC = CW'(N);
  state_t state, nxt;
  sample_t lat_max, lat_min;
  logic [CW-1:0] count;
  logic calc_done;
  logic [2*W-1:0] shifted;
  audio_norm_shift_calc #(.HEADROOM(HEADROOM)) u_calc (
    .clk(clk),
    .reset(reset),
    .start(state == ABS),
    .mx(lat_max),
    .mn(lat_min),
    .done(calc_done),
    .shift(shift)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  // only one output is ever in flight, so count==N with a handshake is the last one
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = mm_done ? ABS : IDLE;
      ABS, NORM: nxt = calc_done ? STREAM : NORM;
      STREAM:    nxt = (count == NC && m_valid && m_ready) ? FIN : STREAM;
      FIN:       nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == FIN;
    s_ready = state == STREAM && count < NC && (!m_valid || m_ready);
    shifted = {{W{s_data[W-1]}}, s_data} << shift;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_max <= '0;
      lat_min <= '0;
      count <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
    end else begin
      if (state == IDLE && mm_done) begin
        lat_max <= in_max;
        lat_min <= in_min;
      end
      if (state != STREAM) count <= '0;
      if (s_valid && s_ready) begin
        m_data <= sat(shifted);
        m_valid <= 1'b1;
        count <= count + 1'b1;
      end else if (m_valid && m_ready) m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_audio_peak_normalizer.sv
// tb_audio_peak_normalizer: directed frames with hand-derived shifts, latencies and saturated outputs.
module tb_audio_peak_normalizer;
  import audio_pkg::*;
  localparam longint HI = 64'sd2147483647;
  localparam longint LO = -64'sd2147483648;
  logic clk = 1'b0;
  logic reset, mm_done, s_valid, m_ready, s_ready, m_valid, busy, done;
  sample_t in_max, in_min, s_data, m_data;
  logic [SW-1:0] shift;
  int passed = 0;
  int total = 0;
  int samp[N];
  longint got[N];
  always #5 clk = ~clk;
  audio_peak_normalizer dut (
    .clk(clk), .reset(reset), .mm_done(mm_done), .in_max(in_max), .in_min(in_min),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .shift(shift), .busy(busy), .done(done)
  );
  function automatic longint model(input longint x, input int sh);
    longint v;
    v = x * (longint'(1) << sh);
    return v > HI ? HI : (v < LO ? LO : v);
  endfunction
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, " s_ready"}, longint'(s_ready), 0);
    chk({tag, " m_valid"}, longint'(m_valid), 0);
    chk({tag, " m_data"}, longint'(m_data), 0);
    chk({tag, " shift"}, longint'(shift), 0);
    chk({tag, " busy"}, longint'(busy), 0);
    chk({tag, " done"}, longint'(done), 0);
  endtask
  task automatic start_frame(input longint mx, input longint mn, input int lat, input int sh, input string tag);
    int c;
    in_max = sample_t'(mx);
    in_min = sample_t'(mn);
    mm_done = 1'b1;
    tick;
    mm_done = 1'b0;
    c = 1;
    while (!s_ready && c < 100) begin
      tick;
      c++;
    end
    chk({tag, " latency"}, c, lat);
    chk({tag, " shift"}, longint'(shift), sh);
  endtask
  task automatic stream(input int sh, input int stall_at, input int abort_at, input string tag);
    int in_idx, out_idx, cyc, dones, stall_left, stall_bad, mism, stop;
    bit stalled;
    sample_t held;
    in_idx = 0; out_idx = 0; cyc = 0; dones = 0; stall_left = 0; stall_bad = 0; stalled = 0;
    held = '0;
    stop = abort_at < N ? abort_at : N;
    while (out_idx < stop && cyc < 2000) begin
      m_ready = stall_left == 0;
      s_valid = in_idx < N;
      s_data = sample_t'(samp[in_idx < N ? in_idx : 0]);
      @(negedge clk);
      if (stall_left == 5) held = m_data;
      if (stall_left > 0 && (!m_valid || m_data !== held || s_ready)) stall_bad++;
      if (done) dones++;
      if (m_valid && m_ready) begin
        got[out_idx] = longint'(m_data);
        out_idx++;
      end
      if (s_valid && s_ready) in_idx++;
      tick;
      if (stall_left > 0) stall_left--;
      else if (!stalled && stall_at >= 0 && out_idx == stall_at) begin
        stall_left = 5;
        stalled = 1;
      end
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk({tag, " outputs"}, out_idx, stop);
    chk({tag, " early done"}, dones, 0);
    mism = 0;
    for (int i = 0; i < out_idx; i++) if (got[i] !== model(longint'(samp[i]), sh)) mism++;
    chk({tag, " data mismatches"}, mism, 0);
    if (stall_at >= 0) begin
      chk({tag, " stall hold"}, stall_bad, 0);
      chk({tag, " stall seen"}, longint'(stalled), 1);
    end
    if (abort_at >= N) begin
      chk({tag, " done pulse"}, longint'(done), 1);
      tick;
      chk({tag, " done cleared"}, longint'(done), 0);
      chk({tag, " busy cleared"}, longint'(busy), 0);
    end
  endtask
  initial begin
    reset = 1'b1; mm_done = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    in_max = '0; in_min = '0; s_data = '0;
    repeat (2) tick;
    check_idle_outputs("reset");
    reset = 1'b0;
    tick;
    for (int i = 0; i < N; i++) samp[i] = i * 13 - 500;
    samp[0] = 1000;
    samp[1] = -500;
    start_frame(1000, -500, 23, 20, "gain20");
    stream(20, -1, N, "gain20");
    chk("gain20 first", got[0], 1048576000);
    chk("gain20 second", got[1], -524288000);
    for (int i = 0; i < N; i++) samp[i] = 0;
    start_frame(0, 0, 2, 0, "zero");
    stream(0, -1, N, "zero");
    chk("zero last", got[N-1], 0);
    for (int i = 0; i < N; i++) samp[i] = -i * 12345;
    samp[0] = int'(32'h80000000);
    samp[1] = 5;
    start_frame(5, LO, 3, 0, "fullscale");
    stream(0, -1, N, "fullscale");
    chk("fullscale min passes", got[0], LO);
    chk("fullscale five", got[1], 5);
    for (int i = 0; i < N; i++) samp[i] = i * 13 - 500;
    samp[0] = 4000;
    samp[1] = -4000;
    start_frame(1000, -500, 23, 20, "sat");
    stream(20, 50, N, "sat");
    chk("sat high", got[0], HI);
    chk("sat low", got[1], LO);
    chk("sat after stall", got[50], model(longint'(samp[50]), 20));
    start_frame(1000, -500, 23, 20, "abort");
    stream(20, -1, 40, "abort");
    reset = 1'b1;
    tick;
    check_idle_outputs("abort reset");
    reset = 1'b0;
    tick;
    start_frame(1000, -500, 23, 20, "restart");
    stream(20, -1, N, "restart");
    chk("restart first", got[0], model(longint'(samp[0]), 20));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
